// File: rtl/hit_judge_pkg.sv
// Shared definitions for the hit judge: window FSM encoding, lane indices,
// debounce defaults and the saturating combo helper.
package hit_judge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OPEN   = 2'd1,
    ST_JUDGED = 2'd2
  } win_state_t;

  localparam int LANE_RED    = 2;
  localparam int LANE_YELLOW = 1;
  localparam int LANE_BLUE   = 0;
  localparam int NUM_LANES   = 3;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 250000;
  localparam int DEFAULT_DB_W            = 18;

  localparam logic [7:0] COMBO_MAX = 8'd255;

  function automatic logic [7:0] sat_inc(input logic [7:0] value);
    return (value == COMBO_MAX) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/hit_judge_if.sv
// Bundle of game-side signals between the note lanes, the buttons and the
// score/combo logic.
interface hit_judge_if;
  // step is a one-cycle strobe with no backpressure: the judge always accepts
  // it; lane_heads is only meaningful while step is high. Pulses out are
  // single-cycle and never both high.
  logic       clear;
  logic       step;
  logic [2:0] lane_heads;
  logic [2:0] keys_n;
  logic       increase_score;
  logic       decrease_score;
  logic [7:0] combo;
  logic [7:0] max_combo;
  logic [1:0] window_state;

  modport master (
    output clear, step, lane_heads, keys_n,
    input  increase_score, decrease_score, combo, max_combo, window_state
  );

  modport slave (
    input  clear, step, lane_heads, keys_n,
    output increase_score, decrease_score, combo, max_combo, window_state
  );
endinterface

// File: rtl/key_debouncer.sv
// One push-button lane: 2-flop synchroniser, stability counter and a
// registered one-cycle pulse on each accepted press.
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int DB_W            = 18
) (
  input  logic clk,
  input  logic resetn,
  input  logic key_n,
  output logic press
);

  localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      sync_q;
  logic [DB_W-1:0] cnt_q;
  logic            level_q;
  logic            sample;

  // Buttons idle high, so the synchroniser resets to the released level.
  assign sample = ~sync_q[1];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], key_n};
      press  <= 1'b0;
      if (sample == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        level_q <= sample;
        cnt_q   <= '0;
        press   <= sample;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/hit_judge.sv
// Judges each note-step window as hit, miss or wrong key from debounced
// presses, pulses the score counters and tracks the current and best combo.
module hit_judge
  import hit_judge_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int DB_W            = DEFAULT_DB_W
) (
  input  logic         clk,
  input  logic         resetn,
  hit_judge_if.slave   bus
);

  logic [NUM_LANES-1:0] press;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    key_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .DB_W           (DB_W)
    ) u_deb (
      .clk   (clk),
      .resetn(resetn),
      .key_n (bus.keys_n[i]),
      .press (press[i])
    );
  end

  win_state_t           state, state_next;
  logic [NUM_LANES-1:0] need, need_next;
  logic [NUM_LANES-1:0] pending, pending_next;
  logic [NUM_LANES-1:0] p;
  logic                 inc_q, dec_q, inc_next, dec_next;
  logic [7:0]           combo_q, combo_next;
  logic [7:0]           max_q, max_next;

  // A press landing this cycle is judged together with anything already pending.
  assign p = pending | press;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= ST_IDLE;
      need    <= '0;
      pending <= '0;
      inc_q   <= 1'b0;
      dec_q   <= 1'b0;
      combo_q <= '0;
      max_q   <= '0;
    end else begin
      state   <= state_next;
      need    <= need_next;
      pending <= pending_next;
      inc_q   <= inc_next;
      dec_q   <= dec_next;
      combo_q <= combo_next;
      max_q   <= max_next;
    end
  end

  always_comb begin
    state_next   = state;
    need_next    = need;
    pending_next = pending | press;
    inc_next     = 1'b0;
    dec_next     = 1'b0;

    if (bus.clear) begin
      state_next   = ST_IDLE;
      need_next    = '0;
      pending_next = '0;
    end else if (bus.step) begin
      // Presses in a step cycle stay pending and meet the new window next cycle.
      dec_next   = (state == ST_OPEN);
      need_next  = bus.lane_heads;
      state_next = (bus.lane_heads != '0) ? ST_OPEN : ST_IDLE;
    end else begin
      pending_next = '0;
      if (p != '0) begin
        case (state)
          ST_IDLE: begin
            dec_next = 1'b1;
          end
          ST_OPEN: begin
            if ((p & ~need) != '0) begin
              dec_next   = 1'b1;
              state_next = ST_JUDGED;
            end else begin
              need_next = need & ~p;
              if ((need & ~p) == '0) begin
                inc_next   = 1'b1;
                state_next = ST_JUDGED;
              end
            end
          end
          ST_JUDGED: begin
            state_next = ST_JUDGED;
          end
          default: begin
            state_next = ST_IDLE;
          end
        endcase
      end
    end

    if (bus.clear) begin
      combo_next = '0;
    end else if (inc_next) begin
      combo_next = sat_inc(combo_q);
    end else if (dec_next) begin
      combo_next = '0;
    end else begin
      combo_next = combo_q;
    end

    if (bus.clear) begin
      max_next = '0;
    end else if (combo_next > max_q) begin
      max_next = combo_next;
    end else begin
      max_next = max_q;
    end
  end

  always_comb begin
    bus.window_state   = state;
    bus.increase_score = inc_q;
    bus.decrease_score = dec_q;
    bus.combo          = combo_q;
    bus.max_combo      = max_q;
  end

endmodule
